vga_pattern_gen: RTL and testbench

- Parametrised VGA timing plus test-pattern generator; successor to the fixed 640x480 three-bar top-level.
- Resolution, porches, sync polarity and colour depth are parameters; four run-time selectable patterns, including a scrolling bar mode.
- Sits between the clock wizard's pixel clock and the board RGB/sync pins.
- Used as a bring-up source ahead of the HDMA framebuffer path.

---
 rtl/vga_pattern_gen_if.sv | 29 ++
 rtl/vga_pattern_gen.sv | 176 +++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_gen_if.sv
// Pixel-side bundle of the pattern generator: run-time controls in, RGB/sync/position out.
interface vga_pattern_gen_if #(
    parameter int COLOR_W = 4,
    parameter int POS_W   = 10
);
    logic               i_enable;
    logic [1:0]         i_mode;
    logic [COLOR_W-1:0] o_red;
    logic [COLOR_W-1:0] o_green;
    logic [COLOR_W-1:0] o_blue;
    logic               o_hsync;
    logic               o_vsync;
    logic               o_video_on;
    logic [POS_W-1:0]   o_hpos;
    logic [POS_W-1:0]   o_vpos;
    logic               o_frame_start;

    modport master (
        input  i_enable, i_mode,
        output o_red, o_green, o_blue, o_hsync, o_vsync,
               o_video_on, o_hpos, o_vpos, o_frame_start
    );

    modport slave (
        output i_enable, i_mode,
        input  o_red, o_green, o_blue, o_hsync, o_vsync,
               o_video_on, o_hpos, o_vpos, o_frame_start
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA raster timing with four test patterns; every output is one registered
// cycle behind the counter state it reflects. Free-running pixel source, no backpressure.
module vga_pattern_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SYNC_POL    = 0,
    parameter int COLOR_W     = 4,
    parameter int POS_W       = 10,
    parameter int NUM_BARS    = 3,
    parameter int CHECK_LOG2  = 5,
    parameter int SCROLL_STEP = 4
) (
    input  logic              i_pixel_clock,
    input  logic              i_reset_n,
    vga_pattern_gen_if.master vid
);
    typedef logic [POS_W-1:0] pos_t;
    typedef logic [POS_W:0]   pos_x_t;

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int BW      = H_ACTIVE / NUM_BARS;

    localparam pos_t   H_LAST       = pos_t'(H_TOTAL - 1);
    localparam pos_t   V_LAST       = pos_t'(V_TOTAL - 1);
    localparam pos_t   H_ACT        = pos_t'(H_ACTIVE);
    localparam pos_t   V_ACT        = pos_t'(V_ACTIVE);
    localparam pos_t   H_ACT_LAST   = pos_t'(H_ACTIVE - 1);
    localparam pos_t   V_ACT_LAST   = pos_t'(V_ACTIVE - 1);
    localparam pos_t   H_SYNC_FIRST = pos_t'(H_ACTIVE + H_FRONT);
    localparam pos_t   H_SYNC_LAST  = pos_t'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam pos_t   V_SYNC_FIRST = pos_t'(V_ACTIVE + V_FRONT);
    localparam pos_t   V_SYNC_LAST  = pos_t'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam pos_x_t H_ACT_X      = pos_x_t'(H_ACTIVE);
    localparam pos_x_t STEP_X       = pos_x_t'(SCROLL_STEP);
    localparam logic   SYNC_ON      = (SYNC_POL != 0);

    pos_t               hcnt_q, hcnt_d;
    pos_t               vcnt_q, vcnt_d;
    logic [1:0]         mode_q, mode_d;
    pos_t               scroll_q, scroll_d;
    logic [COLOR_W-1:0] red_q, red_d;
    logic [COLOR_W-1:0] green_q, green_d;
    logic [COLOR_W-1:0] blue_q, blue_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               video_on_q, video_on_d;
    pos_t               hpos_q, hpos_d;
    pos_t               vpos_q, vpos_d;
    logic               frame_start_q, frame_start_d;

    logic   line_end;
    logic   frame_end;
    logic   in_active;
    logic   rgb_on;
    pos_x_t scroll_sum;
    pos_x_t scroll_x;
    pos_t   bar_x;
    logic [2:0] bar_idx;
    logic [2:0] bar_rgb;
    logic [2:0] pix_rgb;

    // Raster counters plus the once-per-frame updates of mode and scroll offset.
    always_comb begin
        line_end   = (hcnt_q == H_LAST);
        frame_end  = line_end && (vcnt_q == V_LAST);
        hcnt_d     = line_end ? '0 : hcnt_q + pos_t'(1);
        vcnt_d     = vcnt_q;
        if (line_end) begin
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + pos_t'(1);
        end
        mode_d     = mode_q;
        scroll_d   = scroll_q;
        scroll_sum = pos_x_t'(scroll_q) + STEP_X;
        if (frame_end) begin
            mode_d   = vid.i_mode;
            scroll_d = (scroll_sum >= H_ACT_X) ? pos_t'(scroll_sum - H_ACT_X) : pos_t'(scroll_sum);
        end
    end

    // Pixel colour for the current counter state; registered below.
    always_comb begin
        in_active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        rgb_on    = in_active && vid.i_enable;

        scroll_x = pos_x_t'(hcnt_q) + pos_x_t'(scroll_q);
        if (scroll_x >= H_ACT_X) begin
            scroll_x = scroll_x - H_ACT_X;
        end
        bar_x = (mode_q == 2'd2) ? pos_t'(scroll_x) : hcnt_q;

        // The last bar has no upper bound, so it absorbs the division remainder.
        bar_idx = '0;
        for (int k = 1; k < NUM_BARS; k++) begin
            if (bar_x >= pos_t'(k * BW)) begin
                bar_idx = 3'(k);
            end
        end

        case (bar_idx)
            3'd0:    bar_rgb = 3'b100;
            3'd1:    bar_rgb = 3'b010;
            3'd2:    bar_rgb = 3'b001;
            3'd3:    bar_rgb = 3'b110;
            3'd4:    bar_rgb = 3'b011;
            3'd5:    bar_rgb = 3'b101;
            3'd6:    bar_rgb = 3'b111;
            default: bar_rgb = 3'b000;
        endcase

        case (mode_q)
            2'd1:    pix_rgb = {3{hcnt_q[CHECK_LOG2] ^ vcnt_q[CHECK_LOG2]}};
            2'd3:    pix_rgb = {3{(hcnt_q == '0) || (hcnt_q == H_ACT_LAST) ||
                                  (vcnt_q == '0) || (vcnt_q == V_ACT_LAST)}};
            default: pix_rgb = bar_rgb;
        endcase

        red_d         = {COLOR_W{rgb_on & pix_rgb[2]}};
        green_d       = {COLOR_W{rgb_on & pix_rgb[1]}};
        blue_d        = {COLOR_W{rgb_on & pix_rgb[0]}};
        hsync_d       = ((hcnt_q >= H_SYNC_FIRST) && (hcnt_q <= H_SYNC_LAST)) ? SYNC_ON : ~SYNC_ON;
        vsync_d       = ((vcnt_q >= V_SYNC_FIRST) && (vcnt_q <= V_SYNC_LAST)) ? SYNC_ON : ~SYNC_ON;
        video_on_d    = in_active;
        hpos_d        = hcnt_q;
        vpos_d        = vcnt_q;
        frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
    end

    always_ff @(posedge i_pixel_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            mode_q        <= '0;
            scroll_q      <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            hsync_q       <= ~SYNC_ON;
            vsync_q       <= ~SYNC_ON;
            video_on_q    <= 1'b0;
            hpos_q        <= '0;
            vpos_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            mode_q        <= mode_d;
            scroll_q      <= scroll_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vid.o_red         = red_q;
    assign vid.o_green       = green_q;
    assign vid.o_blue        = blue_q;
    assign vid.o_hsync       = hsync_q;
    assign vid.o_vsync       = vsync_q;
    assign vid.o_video_on    = video_on_q;
    assign vid.o_hpos        = hpos_q;
    assign vid.o_vpos        = vpos_q;
    assign vid.o_frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen on a shrunken 80x47 raster (64x40 active, 3 bars of 21/21/22).
// A second instance with SYNC_POL=1 shares clock, reset and controls.
module tb_vga_pattern_gen;
    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 40, VF = 2, VS = 2, VB = 3;
    localparam int HT = 80, VT = 47, FRAME = HT * VT;
    localparam int CW = 4, PW = 7;
    localparam logic [11:0] RED = 12'hF00, GRN = 12'h0F0, BLU = 12'h00F;
    localparam logic [11:0] WHT = 12'hFFF, BLK = 12'h000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    vga_pattern_gen_if #(.COLOR_W(CW), .POS_W(PW)) vif ();
    vga_pattern_gen_if #(.COLOR_W(CW), .POS_W(PW)) vif1 ();

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(0), .COLOR_W(CW), .POS_W(PW), .NUM_BARS(3),
        .CHECK_LOG2(5), .SCROLL_STEP(4)
    ) u_dut (
        .i_pixel_clock(clk),
        .i_reset_n    (rst_n),
        .vid          (vif)
    );

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1), .COLOR_W(CW), .POS_W(PW), .NUM_BARS(3),
        .CHECK_LOG2(5), .SCROLL_STEP(4)
    ) u_dut_pol1 (
        .i_pixel_clock(clk),
        .i_reset_n    (rst_n),
        .vid          (vif1)
    );

    always #5 clk = ~clk;

    logic [11:0] rgb;
    assign rgb = {vif.o_red, vif.o_green, vif.o_blue};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_in(input logic en, input logic [1:0] mode);
        vif.i_enable  = en;
        vif.i_mode    = mode;
        vif1.i_enable = en;
        vif1.i_mode   = mode;
    endtask

    task automatic wait_pos(input string tag, input int h, input int v);
        int n;
        n = 0;
        while (!(int'(vif.o_hpos) == h && int'(vif.o_vpos) == v) && n < 2 * FRAME) begin
            cyc();
            n++;
        end
        if (n >= 2 * FRAME) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic next_frame(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!vif.o_frame_start && n <= FRAME + 10);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rgb"},      rgb, BLK);
        chk({tag, "_video_on"}, vif.o_video_on, 1'b0);
        chk({tag, "_hpos"},     vif.o_hpos, 7'd0);
        chk({tag, "_vpos"},     vif.o_vpos, 7'd0);
        chk({tag, "_fs"},       vif.o_frame_start, 1'b0);
        chk({tag, "_hsync"},    vif.o_hsync, 1'b1);
        chk({tag, "_vsync"},    vif.o_vsync, 1'b1);
        chk({tag, "_hsync_p1"}, vif1.o_hsync, 1'b0);
        chk({tag, "_vsync_p1"}, vif1.o_vsync, 1'b0);
    endtask

    initial begin
        int n, hbad, vbad, hlow, vlow, pbad, von;
        int white, blank_nz, border_bad;
        logic exp_w;

        // Reset held from time 0 with checker mode requested: frame 0 must still be bars.
        set_in(1'b1, 2'd1);
        repeat (3) cyc();
        chk_reset("por");
        rst_n = 1'b1;
        cyc();
        chk("f0_fs", vif.o_frame_start, 1'b1);
        chk("f0_pos", {vif.o_hpos, vif.o_vpos}, 14'd0);
        chk("f0_x0_red", rgb, RED);

        n = 0; hbad = 0; vbad = 0; hlow = 0; vlow = 0; pbad = 0; von = 0;
        do begin
            if (vif.o_hsync !== ((vif.o_hpos >= 68 && vif.o_hpos <= 75) ? 1'b0 : 1'b1)) hbad++;
            if (vif.o_vsync !== ((vif.o_vpos >= 42 && vif.o_vpos <= 43) ? 1'b0 : 1'b1)) vbad++;
            if (!vif.o_hsync) hlow++;
            if (!vif.o_vsync) vlow++;
            if (vif1.o_hsync !== ~vif.o_hsync || vif1.o_vsync !== ~vif.o_vsync) pbad++;
            if (vif.o_video_on) von++;
            if (vif.o_vpos == 0) begin
                case (int'(vif.o_hpos))
                    20: chk("bar_x20", rgb, RED);
                    21: chk("bar_x21", rgb, GRN);
                    41: chk("bar_x41", rgb, GRN);
                    42: chk("bar_x42", rgb, BLU);
                    63: chk("bar_x63", rgb, BLU);
                    64: chk("bar_x64_blank", rgb, BLK);
                    default: ;
                endcase
            end
            cyc();
            n++;
        end while (!vif.o_frame_start && n <= FRAME + 10);
        chk("fs_period", n, FRAME);
        chk("hsync_bad", hbad, 0);
        chk("hsync_low_cnt", hlow, HS * VT);
        chk("vsync_bad", vbad, 0);
        chk("vsync_low_cnt", vlow, VS * HT);
        chk("pol1_bad", pbad, 0);
        chk("video_on_cnt", von, HA * VA);

        // Frame 1: checker.
        chk("chk_0_0", rgb, BLK);
        wait_pos("chk_32_0", 32, 0);
        chk("chk_32_0", rgb, WHT);
        wait_pos("chk_0_32", 0, 32);
        chk("chk_0_32", rgb, WHT);
        wait_pos("chk_32_32", 32, 32);
        chk("chk_32_32", rgb, BLK);

        // Mid-frame asynchronous reset, sampled before any clock edge.
        wait_pos("mid_rst", 30, 36);
        set_in(1'b1, 2'd2);
        #2 rst_n = 1'b0;
        #1 chk_reset("mid");
        repeat (3) cyc();
        chk("mid_hold_hpos", vif.o_hpos, 7'd0);
        rst_n = 1'b1;
        cyc();
        chk("rel_fs", vif.o_frame_start, 1'b1);
        chk("rel_pos", {vif.o_hpos, vif.o_vpos}, 14'd0);
        chk("rel_mode0_red", rgb, RED);
        chk("rel_hsync_p1", vif1.o_hsync, 1'b0);

        // Scrolling bars: frame 1 scroll 4, frame 2 scroll 8.
        next_frame(n);
        chk("b_period", n, FRAME);
        wait_pos("scr1_x16", 16, 0);
        chk("scr1_x16_red", rgb, RED);
        cyc();
        chk("scr1_x17_grn", rgb, GRN);
        wait_pos("pol_x68", 68, 0);
        chk("pol0_hsync_on", vif.o_hsync, 1'b0);
        chk("pol1_hsync_on", vif1.o_hsync, 1'b1);
        next_frame(n);
        wait_pos("scr2_x13", 13, 0);
        chk("scr2_x13_grn", rgb, GRN);
        wait_pos("scr2_x55", 55, 0);
        chk("scr2_x55_blu", rgb, BLU);
        cyc();
        chk("scr2_x56_red", rgb, RED);
        wait_pos("scr2_x62", 62, 0);
        chk("scr2_x62_red", rgb, RED);
        set_in(1'b1, 2'd3);
        wait_pos("mid_mode", 56, 5);
        chk("mid_mode_no_effect", rgb, RED);

        // Frame 3: border, scanned in full.
        next_frame(n);
        white = 0; blank_nz = 0; border_bad = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (rgb == WHT) white++;
            if (vif.o_hpos >= HA && rgb != BLK) blank_nz++;
            exp_w = (vif.o_hpos < HA && vif.o_vpos < VA) &&
                    (vif.o_hpos == 0 || vif.o_hpos == HA - 1 || vif.o_vpos == 0 || vif.o_vpos == VA - 1);
            if (rgb !== (exp_w ? WHT : BLK)) border_bad++;
            if (vif.o_hpos == 1 && vif.o_vpos == 1) chk("brd_1_1", rgb, BLK);
            if (vif.o_hpos == 63 && vif.o_vpos == 20) chk("brd_63_20", rgb, WHT);
            cyc();
        end
        chk("brd_white_cnt", white, 2 * HA + 2 * (VA - 2));
        chk("brd_blank_nz", blank_nz, 0);
        chk("brd_bad", border_bad, 0);
        chk("brd_next_fs", vif.o_frame_start, 1'b1);

        // Enable dropped mid-line: RGB blanks on the next pixel, timing untouched.
        wait_pos("en_off", 62, 5);
        set_in(1'b0, 2'd3);
        cyc();
        chk("en_off_hpos", vif.o_hpos, 7'd63);
        chk("en_off_x63", rgb, BLK);
        wait_pos("en_off_sync", 68, 5);
        chk("en_off_hsync", vif.o_hsync, 1'b0);
        next_frame(n);
        chk("en_off_corner", rgb, BLK);
        next_frame(n);
        chk("en_off_period", n, FRAME);
        set_in(1'b1, 2'd3);
        cyc();
        chk("en_on_row0", rgb, WHT);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
